// File: rtl/hit_readout_if.sv
// Request input and hit output stream of hit_readout.
// master = hit producer (hit_readout), slave = requester/consumer.
interface hit_readout_if #(
  parameter int SSIDBITS  = 10,
  parameter int NCOLS_HIM = 16
) ();
  logic                 reqValid;
  logic [SSIDBITS-1:0]  reqSSID;
  logic                 reqReady;
  logic                 hitValid;
  logic [NCOLS_HIM-1:0] hitInfo;
  logic [SSIDBITS-1:0]  hitSSID;
  logic                 hitLast;
  logic                 hitReady;

  modport master (
    input  reqValid, reqSSID, hitReady,
    output reqReady, hitValid, hitInfo,
    output hitSSID, hitLast
  );

  modport slave (
    output reqValid, reqSSID, hitReady,
    input  reqReady, hitValid, hitInfo,
    input  hitSSID, hitLast
  );
endinterface

// File: rtl/hit_readout.sv
// Reads the hit count for one SSID, then streams
// every stored hit word for it with a last tag.
module hit_readout #(
  parameter int SSIDBITS  = 10,
  parameter int NCOLS_HIM = 16,
  parameter int HITBITS   = 3,
  parameter int COUNTBITS = 4
) (
  input  logic                        clock,
  input  logic                        resetN,
  hit_readout_if.master               io,
  output logic                        cntRead,
  output logic [SSIDBITS-1:0]         cntAddr,
  input  logic [COUNTBITS-1:0]        cntData,
  output logic                        himRead,
  output logic [SSIDBITS+HITBITS-1:0] himAddr,
  input  logic [NCOLS_HIM-1:0]        himData,
  output logic                        done,
  output logic [COUNTBITS-1:0]        doneCount,
  output logic                        overflow
);

  localparam logic [COUNTBITS-1:0] MAXHITS =
    COUNTBITS'(2 ** HITBITS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CNT_RD  = 3'd1;
  localparam logic [2:0] S_CNT_CAP = 3'd2;
  localparam logic [2:0] S_HIM_RD  = 3'd3;
  localparam logic [2:0] S_HIM_CAP = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [SSIDBITS-1:0]  ssid_q, ssid_d;
  logic [COUNTBITS-1:0] cnt_q, cnt_d;
  logic [HITBITS-1:0]   idx_q, idx_d;
  logic [NCOLS_HIM-1:0] info_q, info_d;
  logic [SSIDBITS-1:0]  hssid_q, hssid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic [COUNTBITS-1:0] dcnt_q, dcnt_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    ssid_d  = ssid_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    info_d  = info_q;
    hssid_d = hssid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    dcnt_d  = '0;
    ovf_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io.reqValid) begin
          ssid_d  = io.reqSSID;
          state_d = S_CNT_RD;
        end
      end
      S_CNT_RD: state_d = S_CNT_CAP;
      S_CNT_CAP: begin
        // clamp so the index can never wrap
        if (cntData > MAXHITS) begin
          cnt_d = MAXHITS;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cntData;
        end
        idx_d = '0;
        if (cntData == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HIM_RD;
        end
      end
      S_HIM_RD: state_d = S_HIM_CAP;
      S_HIM_CAP: begin
        info_d  = himData;
        hssid_d = ssid_q;
        last_d  = (COUNTBITS'(idx_q) ==
                   cnt_q - COUNTBITS'(1));
        state_d = S_OUT;
      end
      S_OUT: begin
        if (io.hitReady) begin
          if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dcnt_d  = cnt_q;
          end else begin
            idx_d   = idx_q + HITBITS'(1);
            state_d = S_HIM_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      ssid_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      info_q  <= '0;
      hssid_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ssid_q  <= ssid_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      info_q  <= info_d;
      hssid_q <= hssid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.reqReady = (state_q == S_IDLE);
  assign io.hitValid = (state_q == S_OUT);
  assign io.hitInfo  = info_q;
  assign io.hitSSID  = hssid_q;
  assign io.hitLast  = last_q;

  assign cntRead   = (state_q == S_CNT_RD);
  assign cntAddr   = ssid_q;
  assign himRead   = (state_q == S_HIM_RD);
  assign himAddr   = {ssid_q, idx_q};
  assign done      = done_q;
  assign doneCount = dcnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_hit_readout.sv
// Self-checking bench for hit_readout: RAM models,
// a transaction-level reference model and directed cases.
module tb_hit_readout;
  localparam int SB = 10;
  localparam int NH = 16;
  localparam int HB = 3;
  localparam int CB = 4;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  hit_readout_if #(.SSIDBITS(SB), .NCOLS_HIM(NH)) io ();

  logic             cntRead;
  logic [SB-1:0]    cntAddr;
  logic [CB-1:0]    cntData;
  logic             himRead;
  logic [SB+HB-1:0] himAddr;
  logic [NH-1:0]    himData;
  logic             done;
  logic [CB-1:0]    doneCount;
  logic             overflow;

  hit_readout #(
    .SSIDBITS(SB), .NCOLS_HIM(NH),
    .HITBITS(HB), .COUNTBITS(CB)
  ) dut (
    .clock(clock), .resetN(resetN), .io(io),
    .cntRead(cntRead), .cntAddr(cntAddr),
    .cntData(cntData), .himRead(himRead),
    .himAddr(himAddr), .himData(himData),
    .done(done), .doneCount(doneCount),
    .overflow(overflow)
  );

  logic [CB-1:0] cnt_mem [1024];
  logic [NH-1:0] him_mem [8192];

  always @(posedge clock) begin
    if (cntRead) cntData <= cnt_mem[cntAddr];
    if (himRead) himData <= him_mem[himAddr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h cycle %0d",
                  nm, act, exp, cyc);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // reference model: one outstanding request, timed by rules
  bit m_busy = 1'b0;
  bit m_ovf;
  int m_ssid, m_n, m_idx, m_acc, m_nv, m_dc, m_c;
  bit e_cnt, e_him, e_hv, e_done, e_ovf, e_rdy;

  int          l_hv_t[$];
  logic [15:0] l_hv_info[$];
  int          l_hv_ssid[$];
  int          l_hv_last[$];
  int          l_done_t[$];
  int          l_dcnt[$];
  int          l_ovf_t[$];
  int          l_him_t[$];
  int          l_him_a[$];
  int          l_cnt_t[$];

  task automatic clear_logs();
    l_hv_t.delete();   l_hv_info.delete();
    l_hv_ssid.delete(); l_hv_last.delete();
    l_done_t.delete(); l_dcnt.delete();
    l_ovf_t.delete();  l_him_t.delete();
    l_him_a.delete();  l_cnt_t.delete();
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!resetN) begin
        chk("rst_hitValid", 32'(io.hitValid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_reqReady", 32'(io.reqReady), 1);
        m_busy = 1'b0;
      end else begin
        e_cnt  = m_busy && cyc == m_acc + 1;
        e_ovf  = m_busy && m_ovf && cyc == m_acc + 3;
        e_done = m_busy && cyc == m_dc;
        e_rdy  = !m_busy || e_done;
        e_hv   = m_busy && m_idx < m_n && cyc >= m_nv;
        e_him  = m_busy && m_idx < m_n && cyc == m_nv - 2;
        chk("cntRead", 32'(cntRead), 32'(e_cnt));
        if (e_cnt) chk("cntAddr", 32'(cntAddr), m_ssid);
        chk("himRead", 32'(himRead), 32'(e_him));
        if (e_him)
          chk("himAddr", 32'(himAddr), m_ssid * 8 + m_idx);
        chk("hitValid", 32'(io.hitValid), 32'(e_hv));
        if (e_hv) begin
          chk("hitInfo", 32'(io.hitInfo),
              32'(him_mem[m_ssid * 8 + m_idx]));
          chk("hitSSID", 32'(io.hitSSID), m_ssid);
          chk("hitLast", 32'(io.hitLast),
              32'(m_idx == m_n - 1));
        end
        chk("done", 32'(done), 32'(e_done));
        if (e_done) chk("doneCount", 32'(doneCount), m_n);
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("reqReady", 32'(io.reqReady), 32'(e_rdy));
        if (io.hitValid) begin
          l_hv_t.push_back(cyc);
          l_hv_info.push_back(io.hitInfo);
          l_hv_ssid.push_back(int'(io.hitSSID));
          l_hv_last.push_back(int'(io.hitLast));
        end
        if (done) begin
          l_done_t.push_back(cyc);
          l_dcnt.push_back(int'(doneCount));
        end
        if (overflow) l_ovf_t.push_back(cyc);
        if (himRead) begin
          l_him_t.push_back(cyc);
          l_him_a.push_back(int'(himAddr));
        end
        if (cntRead) l_cnt_t.push_back(cyc);
        if (e_done) m_busy = 1'b0;
        if (e_hv && io.hitReady) begin
          if (m_idx == m_n - 1) m_dc = cyc + 1;
          else m_nv = cyc + 3;
          m_idx++;
        end
        if (e_rdy && io.reqValid) begin
          m_busy = 1'b1;
          m_acc  = cyc;
          m_ssid = int'(io.reqSSID);
          m_c    = int'(cnt_mem[io.reqSSID]);
          m_ovf  = m_c > 8;
          m_n    = (m_c > 8) ? 8 : m_c;
          m_idx  = 0;
          m_nv   = cyc + 5;
          m_dc   = (m_n == 0) ? cyc + 3 : -1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int a;

  task automatic request(int ssid);
    io.reqSSID  = SB'(ssid);
    io.reqValid = 1'b1;
    a = cyc;
    step(1);
    io.reqValid = 1'b0;
  endtask

  initial begin
    io.reqValid = 1'b0;
    io.reqSSID  = '0;
    io.hitReady = 1'b0;
    for (int i = 0; i < 1024; i++)
      cnt_mem[i] = CB'($urandom_range(0, 15));
    for (int i = 0; i < 8192; i++)
      him_mem[i] = NH'($urandom);
    step(3);
    chk("reset_reqReady", 32'(io.reqReady), 1);
    chk("reset_hitValid", 32'(io.hitValid), 0);
    chk("reset_cntRead", 32'(cntRead), 0);
    chk("reset_himRead", 32'(himRead), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_hitInfo", 32'(io.hitInfo), 0);
    resetN = 1'b1;
    step(2);

    // count 3, fully ready consumer
    cnt_mem[5] = 4'd3;
    for (int i = 0; i < 8; i++) him_mem[5 * 8 + i] = NH'(16'hA000 + i);
    io.hitReady = 1'b1;
    clear_logs();
    request(5);
    step(15);
    chk("t1_nhits", l_hv_t.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_hit_cycle", l_hv_t[i], a + 5 + 3 * i);
      chk("t1_hit_info", 32'(l_hv_info[i]), 32'h0000A000 + i);
      chk("t1_hit_last", l_hv_last[i], (i == 2) ? 1 : 0);
    end
    chk("t1_done_cycle", l_done_t[0], a + 12);
    chk("t1_done_cnt", l_dcnt[0], 3);

    // count 0
    cnt_mem[10'h3FF] = 4'd0;
    clear_logs();
    request(10'h3FF);
    step(6);
    chk("t2_ndone", l_done_t.size(), 1);
    chk("t2_done_cycle", l_done_t[0], a + 3);
    chk("t2_done_cnt", l_dcnt[0], 0);
    chk("t2_ncntread", l_cnt_t.size(), 1);
    chk("t2_nhits", l_hv_t.size(), 0);

    // first hit stalled for 4 cycles
    cnt_mem[9] = 4'd2;
    io.hitReady = 1'b0;
    clear_logs();
    request(9);
    step(8);
    io.hitReady = 1'b1;
    step(10);
    chk("t3_nvalid", l_hv_t.size(), 6);
    for (int i = 0; i < 5; i++)
      chk("t3_stable", 32'(l_hv_info[i]), 32'(him_mem[9 * 8]));
    chk("t3_him2_cycle", l_him_t[1], a + 10);
    chk("t3_done_cycle", l_done_t[0], a + 13);

    // stored count above capacity
    cnt_mem[10'h155] = 4'd12;
    clear_logs();
    request(10'h155);
    step(30);
    chk("t4_novf", l_ovf_t.size(), 1);
    chk("t4_ovf_cycle", l_ovf_t[0], a + 3);
    chk("t4_nhimrd", l_him_a.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("t4_him_addr", l_him_a[i], 10'h155 * 8 + i);
    chk("t4_done_cnt", l_dcnt[0], 8);

    // back-to-back with reqValid held
    cnt_mem[1] = 4'd2;
    cnt_mem[2] = 4'd3;
    clear_logs();
    io.reqSSID  = 10'd1;
    io.reqValid = 1'b1;
    a = cyc;
    step(1);
    io.reqSSID = 10'd2;
    step(9);
    io.reqValid = 1'b0;
    step(15);
    chk("t5_ndone", l_done_t.size(), 2);
    chk("t5_done1", l_done_t[0], a + 9);
    chk("t5_done2", l_done_t[1], a + 21);
    chk("t5_dcnt2", l_dcnt[1], 3);
    chk("t5_nhits", l_hv_ssid.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t5_ssid_order", l_hv_ssid[i], (i < 2) ? 1 : 2);

    // reset while second of 4 hits is pending
    cnt_mem[7] = 4'd4;
    clear_logs();
    request(7);
    step(7);
    io.hitReady = 1'b0;
    step(1);
    #2;
    resetN = 1'b0;
    #1;
    chk("t6_hitValid", 32'(io.hitValid), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_reqReady", 32'(io.reqReady), 1);
    chk("t6_no_done", l_done_t.size(), 0);
    step(2);
    resetN = 1'b1;
    io.hitReady = 1'b1;
    step(1);
    clear_logs();
    request(7);
    step(20);
    chk("t6_nhimrd", l_him_a.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t6_him_addr", l_him_a[i], 7 * 8 + i);
    chk("t6_done_cnt", l_dcnt[0], 4);

    // randomized traffic
    for (int i = 0; i < 16; i++)
      cnt_mem[i] = CB'($urandom_range(0, 15));
    for (int i = 0; i < 500; i++) begin
      io.reqValid = ($urandom_range(0, 2) == 0);
      io.reqSSID  = SB'($urandom_range(0, 15));
      io.hitReady = ($urandom_range(0, 3) != 0);
      step(1);
    end
    io.reqValid = 1'b0;
    io.hitReady = 1'b1;
    for (int i = 0; i < 300 && m_busy; i++) step(1);
    step(2);
    chk("drain_reqReady", 32'(io.reqReady), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
